ysyx_25040105_idu: RTL

Registered instruction decoder feeding the EXU's control interface. It accepts one fetched instruction per handshake from the IFU, decodes the RV32I subset the EXU implements, and holds the decoded bundle in a single-entry output stage under valid/ready flow control. It also detects ebreak and illegal encodings, and halts intake after either.

---
 rtl/ysyx_25040105_idu.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ysyx_25040105_idu.sv
// RV32I-subset instruction decoder with a single registered output stage.
// Halts intake after accepting ebreak or an unsupported encoding; only reset resumes.
module ysyx_25040105_idu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [3:0]      out_alu_op,
    output logic            out_alu_src,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_rd_wen,
    output logic            out_ebreak,
    output logic            out_illegal,
    output logic            halted,
    output logic [31:0]     dec_count
);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_SLL   = 4'b0010;
    localparam logic [3:0] OP_SRL   = 4'b0011;
    localparam logic [3:0] OP_AUIPC = 4'b0100;
    localparam logic [3:0] OP_LUI   = 4'b0101;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [3:0]      alu_op;
        logic            alu_src;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            rd_wen;
        logic            ebreak;
        logic            illegal;
    } bundle_t;

    typedef enum logic {RUN, HALT} state_t;

    state_t  state, state_nxt;
    bundle_t dec, bnd;
    logic    vld;
    logic    legal;
    logic    accept;

    wire [6:0] opcode = in_inst[6:0];
    wire [2:0] funct3 = in_inst[14:12];
    wire [6:0] funct7 = in_inst[31:25];

    always_comb begin
        dec         = '0;
        dec.pc      = in_pc;
        dec.rs1     = in_inst[19:15];
        dec.rs2     = in_inst[24:20];
        dec.rd      = in_inst[11:7];
        dec.alu_op  = OP_ADD;
        dec.ebreak  = (in_inst == 32'h0010_0073);
        legal       = 1'b1;
        case (opcode)
            7'b0110111: begin
                dec.alu_op  = OP_LUI;
                dec.alu_src = 1'b1;
                dec.imm     = {in_inst[31:12], 12'b0};
            end
            7'b0010111: begin
                dec.alu_op  = OP_AUIPC;
                dec.alu_src = 1'b1;
                dec.imm     = {in_inst[31:12], 12'b0};
            end
            7'b0010011: begin
                dec.alu_src = 1'b1;
                case (funct3)
                    3'b000: dec.imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
                    3'b001: begin
                        dec.alu_op = OP_SLL;
                        dec.imm    = {{(XLEN-5){1'b0}}, in_inst[24:20]};
                        legal      = (funct7 == 7'b0);
                    end
                    3'b101: begin
                        dec.alu_op = OP_SRL;
                        dec.imm    = {{(XLEN-5){1'b0}}, in_inst[24:20]};
                        legal      = (funct7 == 7'b0);
                    end
                    default: legal = 1'b0;
                endcase
            end
            7'b0110011: begin
                case ({funct7, funct3})
                    10'b0000000_000: dec.alu_op = OP_ADD;
                    10'b0100000_000: dec.alu_op = OP_SUB;
                    10'b0000000_001: dec.alu_op = OP_SLL;
                    10'b0000000_101: dec.alu_op = OP_SRL;
                    default:         legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
        // ebreak and illegal words both collapse to a plain ADD with no operands
        if (dec.ebreak || !legal) begin
            dec.alu_op  = OP_ADD;
            dec.alu_src = 1'b0;
            dec.imm     = '0;
        end
        dec.illegal = !legal && !dec.ebreak;
        dec.rd_wen  = legal && !dec.ebreak && (dec.rd != 5'd0);
    end

    assign in_ready = (state == RUN) && (!vld || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        if (state == RUN && accept && (dec.ebreak || dec.illegal))
            state_nxt = HALT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            vld       <= 1'b0;
            bnd       <= '0;
            dec_count <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                vld       <= 1'b1;
                bnd       <= dec;
                dec_count <= dec_count + 32'd1;
            end else if (out_ready) begin
                vld <= 1'b0;
            end
        end
    end

    assign out_valid   = vld;
    assign out_pc      = bnd.pc;
    assign out_imm     = bnd.imm;
    assign out_alu_op  = bnd.alu_op;
    assign out_alu_src = bnd.alu_src;
    assign out_rs1     = bnd.rs1;
    assign out_rs2     = bnd.rs2;
    assign out_rd      = bnd.rd;
    assign out_rd_wen  = bnd.rd_wen;
    assign out_ebreak  = bnd.ebreak;
    assign out_illegal = bnd.illegal;
    assign halted      = (state == HALT);

endmodule
